// File: rtl/wb_ram_bridge_pkg.sv
// ============================================================================
// Module   : wb_ram_bridge_pkg
// Brief    : Shared Wishbone cycle-type and bridge state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_ram_bridge_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2
  } state_t;

  // Only linear incrementing bursts continue; every other cti ends the access.
  function automatic logic cti_continues(input logic [2:0] cti);
    return (cti == CTI_INCR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_bridge.sv
// ============================================================================
// Module   : wb_ram_bridge
// Brief    : Wishbone B3 slave front-end for a synchronous byte-select RAM,
//            classic and linear-burst cycles. Optional address range error
//            termination under macro WB_RAM_BRIDGE_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ram_bridge
  import wb_ram_bridge_pkg::*;
#(
  parameter int          AW        = 13,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_sel,
  output logic [DW-1:0] ram_di,
  output logic          ram_we,
  input  logic [DW-1:0] ram_doq
);

  state_t      r_state;
  logic        r_ack;
  logic        r_err;
  logic        w_req;
  logic        w_incr;
  logic        w_prefetch;
  logic        w_ok_cur;
  logic        w_ok_next;
  logic        w_unused;

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_incr = cti_continues(wb_cti_i);

`ifdef WB_RAM_BRIDGE_ERR_EN
  logic [29:0] w_next_word;

  // The next burst beat is judged on its own predicted address.
  assign w_next_word = wb_adr_i[31:2] + 30'd1;
  assign w_ok_cur    = (wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_ok_next   = (w_next_word[29:AW] == BASE_ADDR[31:AW+2]);
`else
  assign w_ok_cur    = 1'b1;
  assign w_ok_next   = 1'b1;
`endif

  assign w_unused = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], BASE_ADDR};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state <= ACK;
            r_ack   <= w_ok_cur;
            r_err   <= ~w_ok_cur;
          end
        end
        ACK, BURST: begin
          if (!r_err && w_req && w_incr) begin
            r_state <= BURST;
            r_ack   <= w_ok_next;
            r_err   <= ~w_ok_next;
          end else begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Reads look one word ahead during a burst so each beat lands one clock apart.
  assign w_prefetch = ~wb_we_i & r_ack & w_incr;
  assign ram_addr   = wb_adr_i[AW+1:2] + {{(AW-1){1'b0}}, w_prefetch};

  assign ram_sel  = wb_sel_i;
  assign ram_di   = wb_dat_i;
  assign ram_we   = w_req & wb_we_i & r_ack;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_ack ? ram_doq : '0;

endmodule

`default_nettype wire

// File: doc/wb_ram_bridge.md
Name: wb_ram_bridge

Overview:
- Wishbone B3 slave front-end that sits directly upstream of the synchronous single-port byte-select RAM in the writeback-stage memory subsystem.
- Translates CPU data-bus cycles into RAM address, select, data and write-enable, and returns read data with registered acknowledge.
- Supports classic single cycles and linear incrementing bursts (cti=3'b010), so cache line refills stream at one beat per clock.

Parameters:
- AW, 13, RAM word-address width; RAM depth is 2^AW words.
- DW, 32, data width; fixed at 32, with 4 byte lanes.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; used only when the error feature is on.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  32  byte address; bits [1:0] ignored
- wb_sel_i  in  4  byte lane enables
- wb_dat_i  in  32  write data
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- ram_addr  out  AW  RAM word address
- ram_sel  out  4  RAM byte select
- ram_di  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_doq  in  32  RAM read data; valid the cycle after ram_addr is sampled

Behaviour:
- Reset (rst=0, asynchronous): wb_ack_o=0, wb_err_o=0, state=IDLE.
  - ram_we is combinational from wb_ack_o, so it is 0 immediately.
  - Reset mid-burst abandons the burst. No partial write occurs after reset asserts.
- Request definition: req = wb_cyc_i & wb_stb_i.
- State machine: IDLE, ACK, BURST.
  - IDLE -> ACK when req.
  - ACK -> BURST if req & cti==010. Otherwise ACK -> IDLE.
  - BURST stays while req & cti==010. BURST -> IDLE on cti==111 (last beat acked) or on req=0.
- wb_ack_o is registered. It is high in ACK and BURST while req holds; the state register and ack register may be one and the same.
- Latency:
  - Classic read or write: request in cycle N, ack in N+1.
  - Ack is always low in the cycle after a classic ack, so back-to-back classic cycles cost 2 clocks each.
- Write:
  - ram_we = req & wb_we_i & wb_ack_o. The write happens on the acked cycle, using the current wb_adr_i, wb_sel_i and wb_dat_i.
  - ram_sel = wb_sel_i and ram_di = wb_dat_i, combinational.
  - sel=0000 still acks and leaves memory unchanged.
- Read:
  - wb_dat_o = ram_doq, passed through combinationally and qualified by wb_ack_o. It is 0 when ack is low.
  - ram_sel has no effect on reads.
- ram_addr:
  - Equals wb_adr_i[AW+1:2] by default.
  - During a read while ack is high and cti==010, it equals wb_adr_i[AW+1:2]+1. This prefetches the next beat so a burst delivers one word per clock.
- Address arithmetic is modulo 2^AW: a burst at word 2^AW-1 wraps to word 0.
- Only linear bursts are supported. cti values other than 000, 010 and 111 are treated as classic.
- wb_cyc_i dropping mid-burst: ack goes low next cycle, state returns to IDLE, and no write happens in the drop cycle.
- wb_we_i must be stable for a whole burst. A change mid-burst is a master protocol violation and the behaviour is undefined.

Optional Feature:
- Macro: WB_RAM_BRIDGE_ERR_EN.
- Defined:
  - An access with wb_adr_i[31:AW+2] != BASE_ADDR[31:AW+2] gets wb_err_o instead of wb_ack_o, with identical timing (registered, one cycle).
  - ram_we is forced to 0 for that access.
  - A burst that crosses out of range errors on the offending beat and returns to IDLE.
- Undefined:
  - wb_err_o is tied to 0 and the upper address bits are ignored, so the RAM aliases across the whole address space.
  - No comparator logic is generated.

Decomposition:
- Shared package holds:
  - CTI encodings: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State encoding: IDLE=2'd0, ACK=2'd1, BURST=2'd2.
- No sub-module is needed. The optional range check is small enough to stay inline under the macro.

Test Plan:
- Reset: hold rst=0 with req=1 and we=1 -> ack=0, err=0, ram_we=0 throughout. Release rst -> first ack appears 1 cycle after the next req.
- Classic write then read: write adr=0x10, sel=1111, dat=0xDEADBEEF. Then read 0x10 -> ack in the second cycle of each access, ram_addr=4, read dat_o=0xDEADBEEF.
- Byte write: pre-fill word 4 = 0x11223344, write sel=0010 with dat=0x0000AA00 -> readback 0x1122AA44.
- Read burst of 4 from 0x100 (cti 010,010,010,111), memory holding 0xA0..0xA3 -> acks on 4 consecutive cycles, dat_o=0xA0,0xA1,0xA2,0xA3, ack low after the last beat.
- Wrap and abort:
  - Burst read starting at word 8191 -> second beat returns word 0.
  - Separately, drop cyc after 2 write beats -> only 2 words are modified, and state returns to IDLE.
- With WB_RAM_BRIDGE_ERR_EN, BASE_ADDR=0: write to 0x0001_0000 -> err=1 for one cycle, ack=0, memory unchanged. Read 0x0 -> normal ack.
